// File: rtl/uart_rx_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_engine : oversampled UART receiver, valid/ready output, err events  |
// | Option macro UART_RX_MAJORITY_VOTE_EN : 3-sample majority vote per bit      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx_engine #(
  parameter int DATA_MAX     = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                baud_tick,
  input  logic                rx_en,
  input  logic                rxd,
  input  logic [3:0]          data_len,
  input  logic                parity_en,
  input  logic                parity_odd,
  input  logic                stop_twice,
  input  logic                rx_ready,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                rx_valid,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun_err,
  output logic                break_det,
  output logic                timeout_flag,
  output logic                busy
);

  localparam int                 c_cnt_w   = $clog2(OVERSAMPLE);
  localparam int                 c_to_w    = $clog2(TIMEOUT_BITS + 1);
  localparam logic [c_cnt_w-1:0] c_mid     = c_cnt_w'(OVERSAMPLE / 2);
  localparam logic [c_cnt_w-1:0] c_mid_m1  = c_cnt_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(OVERSAMPLE - 1);
  localparam logic [3:0]         c_len_max = 4'(DATA_MAX);
  localparam logic [c_to_w-1:0]  c_to_last = c_to_w'(TIMEOUT_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP_0 = 3'd4,
    S_STOP_1 = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rxd_s1, r_rxd_s2;
  logic [c_cnt_w-1:0]  r_tick_cnt;
  logic [3:0]          r_bit_cnt, r_len;
  logic                r_par_en, r_par_odd, r_stop_twice;
  logic [DATA_MAX-1:0] r_shift;
  logic                r_par_acc, r_all_zero, r_perr, r_ferr, r_brk;
  logic                r_samp_b;
  logic [c_to_w-1:0]   r_idle_cnt;
  logic                r_to_armed;

  logic                w_bit, w_mid, w_start, w_complete;
  logic                w_ferr_fin, w_brk_fin;
  logic [3:0]          w_len;

  // The tick counter is never restarted after the start edge, so every
  // later bit is decided at the same phase as the start bit.
  assign w_mid   = baud_tick && (r_tick_cnt == c_mid);
  assign w_start = (r_state == S_IDLE) && rx_en && baud_tick && !r_rxd_s2;
  assign w_len   = (data_len < 4'd5) ? 4'd5 :
                   (data_len > c_len_max) ? c_len_max : data_len;
  assign busy    = (r_state != S_IDLE);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_samp_a;
  assign w_bit = (r_samp_a & r_samp_b) | (r_samp_a & r_rxd_s2) | (r_samp_b & r_rxd_s2);
`else
  assign w_bit = r_samp_b;
`endif

  assign w_ferr_fin = r_ferr | ~w_bit;
  assign w_brk_fin  = (r_state == S_STOP_0) ? (r_all_zero & ~w_bit) : r_brk;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    if (r_state != S_IDLE && !rx_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_start) w_state_nxt = S_START;
        S_START:  if (w_mid) w_state_nxt = w_bit ? S_IDLE : S_DATA;
        S_DATA:   if (w_mid && (r_bit_cnt == r_len - 4'd1))
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP_0;
        S_PARITY: if (w_mid) w_state_nxt = S_STOP_0;
        S_STOP_0: if (w_mid) begin
                    if (r_stop_twice) begin
                      w_state_nxt = S_STOP_1;
                    end else begin
                      w_state_nxt = S_IDLE;
                      w_complete  = 1'b1;
                    end
                  end
        S_STOP_1: if (w_mid) begin
                    w_state_nxt = S_IDLE;
                    w_complete  = 1'b1;
                  end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rxd_s1     <= 1'b1;
      r_rxd_s2     <= 1'b1;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_len        <= '0;
      r_par_en     <= 1'b0;
      r_par_odd    <= 1'b0;
      r_stop_twice <= 1'b0;
      r_shift      <= '0;
      r_par_acc    <= 1'b0;
      r_all_zero   <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_brk        <= 1'b0;
      r_samp_b     <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      r_samp_a     <= 1'b1;
`endif
    end else begin
      r_rxd_s1 <= rxd;
      r_rxd_s2 <= r_rxd_s1;
      if (baud_tick) r_tick_cnt <= (r_tick_cnt == c_last) ? '0 : r_tick_cnt + 1'b1;
      if (baud_tick && r_tick_cnt == c_mid_m1) r_samp_b <= r_rxd_s2;
`ifdef UART_RX_MAJORITY_VOTE_EN
      if (baud_tick && r_tick_cnt == c_mid_m1 - 1'b1) r_samp_a <= r_rxd_s2;
`endif
      if (w_start) begin
        r_tick_cnt   <= '0;
        r_bit_cnt    <= '0;
        r_len        <= w_len;
        r_par_en     <= parity_en;
        r_par_odd    <= parity_odd;
        r_stop_twice <= stop_twice;
        r_shift      <= '0;
        r_par_acc    <= 1'b0;
        r_all_zero   <= 1'b1;
        r_perr       <= 1'b0;
        r_ferr       <= 1'b0;
        r_brk        <= 1'b0;
      end else if (w_mid && rx_en) begin
        case (r_state)
          S_DATA: begin
            for (int i = 0; i < DATA_MAX; i++)
              if (r_bit_cnt == 4'(i)) r_shift[i] <= w_bit;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            r_par_acc  <= r_par_acc ^ w_bit;
            r_all_zero <= r_all_zero & ~w_bit;
          end
          S_PARITY: begin
            r_perr     <= (w_bit != (r_par_acc ^ r_par_odd));
            r_all_zero <= r_all_zero & ~w_bit;
          end
          S_STOP_0: begin
            r_ferr <= ~w_bit;
            r_brk  <= r_all_zero & ~w_bit;
          end
          default: ;
        endcase
      end
    end
  end

  // Output register, event pulses and the idle-timeout counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
      break_det    <= 1'b0;
      timeout_flag <= 1'b0;
      r_idle_cnt   <= '0;
      r_to_armed   <= 1'b0;
    end else begin
      overrun_err  <= 1'b0;
      break_det    <= 1'b0;
      timeout_flag <= 1'b0;
      if (w_complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= r_shift;
          parity_err <= r_perr;
          frame_err  <= w_ferr_fin;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
        break_det  <= w_brk_fin;
        r_to_armed <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (w_start) begin
        r_idle_cnt <= '0;
      end else if (r_state == S_IDLE && r_to_armed && w_mid && r_rxd_s2) begin
        if (r_idle_cnt == c_to_last) begin
          timeout_flag <= 1'b1;
          r_to_armed   <= 1'b0;
          r_idle_cnt   <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
